// File: rtl/tlb_unit.sv
// Joint MIPS TLB: registered I/D translation, TLBP/TLBR/TLBWI/TLBWR execution and the Random index.
// Lookups have latency 1. TLBP registers its match vector, then encodes it one cycle later.

package tlb_pkg;
    typedef enum logic [2:0] {
        TLB_NONE = 3'd0,
        TLB_P    = 3'd1,
        TLB_R    = 3'd2,
        TLB_WI   = 3'd3,
        TLB_WR   = 3'd4
    } tlb_type_t;

    typedef struct packed {
        logic [31:0] index;
        logic [31:0] entry_hi;
        logic [31:0] entry_lo0;
        logic [31:0] entry_lo1;
    } mmu_resp_t;

    typedef struct packed {
        logic refill;
        logic invalid;
        logic modified;
    } tlb_exc_t;
endpackage

// Per-entry tag compare against the I, D and probe addresses.
module tlb_cmp (
    input  logic [18:0] vpn2,
    input  logic [7:0]  asid,
    input  logic        g,
    input  logic [7:0]  cur_asid,
    input  logic [18:0] i_vpn2,
    input  logic [18:0] d_vpn2,
    input  logic [18:0] p_vpn2,
    output logic        i_hit,
    output logic        d_hit,
    output logic        p_hit
);
    logic asid_ok;

    assign asid_ok = g | (asid == cur_asid);
    assign i_hit   = asid_ok & (vpn2 == i_vpn2);
    assign d_hit   = asid_ok & (vpn2 == d_vpn2);
    assign p_hit   = asid_ok & (vpn2 == p_vpn2);
endmodule

module tlb_unit
    import tlb_pkg::*;
#(
    parameter int TLB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  tlb_type_t   tlb_type,
    output logic        cmd_ready,
    input  logic [31:0] cp0_index,
    input  logic [31:0] cp0_entry_hi,
    input  logic [31:0] cp0_entry_lo0,
    input  logic [31:0] cp0_entry_lo1,
    input  logic [31:0] cp0_wired,
    output logic        resp_valid,
    output mmu_resp_t   mmu_resp,
    output logic [31:0] random,
    input  logic        i_req,
    input  logic [31:0] i_vaddr,
    output logic        i_resp_valid,
    output logic [31:0] i_paddr,
    output logic        i_uncached,
    output tlb_exc_t    i_tlb_exc,
    input  logic        d_req,
    input  logic [31:0] d_vaddr,
    input  logic        d_write,
    output logic        d_resp_valid,
    output logic [31:0] d_paddr,
    output logic        d_uncached,
    output tlb_exc_t    d_tlb_exc
);
    localparam int IW = $clog2(TLB_ENTRIES);
    localparam logic [IW-1:0] TOP_IDX = IW'(TLB_ENTRIES - 1);

    typedef struct packed {
        logic [31:0] paddr;
        logic        uncached;
        tlb_exc_t    exc;
    } lk_t;

    typedef enum logic {S_IDLE, S_PROBE} state_t;

    // lo words are stored without g: {pfn[19:0], c[2:0], d, v}
    logic [TLB_ENTRIES-1:0][18:0] e_vpn2;
    logic [TLB_ENTRIES-1:0][7:0]  e_asid;
    logic [TLB_ENTRIES-1:0]       e_g;
    logic [TLB_ENTRIES-1:0][24:0] e_lo0;
    logic [TLB_ENTRIES-1:0][24:0] e_lo1;

    logic [TLB_ENTRIES-1:0] i_hits, d_hits, p_hits, probe_hits;
    logic [IW:0]            i_sel, d_sel, p_sel;
    logic [24:0]            i_lo, d_lo;
    lk_t                    i_lk, d_lk;
    state_t                 state, state_nx;
    logic                   accept, do_write, resp_fire;
    logic [IW-1:0]          w_idx, r_idx, rnd;
    mmu_resp_t              resp_nx;
    logic                   unused_bits;

    assign unused_bits = ^{cp0_entry_hi[12:8], cp0_entry_lo0[31:26], cp0_entry_lo1[31:26]};

    // {found, index} of the lowest set bit
    function automatic logic [IW:0] first_hit(input logic [TLB_ENTRIES-1:0] hits);
        logic [IW:0] r;
        r = '0;
        for (int k = TLB_ENTRIES - 1; k >= 0; k--)
            if (hits[k]) r = {1'b1, IW'(k)};
        return r;
    endfunction

    function automatic lk_t xlate(input logic req, input logic [31:0] va, input logic hit,
                                  input logic [24:0] lo, input logic wr);
        lk_t r;
        r = '0;
        if (req) begin
            if (va[31:30] == 2'b10) begin
                // kseg0/kseg1: unmapped, va[29] distinguishes the uncached window
                r.paddr    = {3'b000, va[28:0]};
                r.uncached = va[29];
            end else begin
                r.paddr    = {lo[24:5], va[11:0]};
                r.uncached = (lo[4:2] != 3'd3);
                if (!hit)
                    r.exc.refill = 1'b1;
                else if (!lo[0])
                    r.exc.invalid = 1'b1;
                else if (wr && !lo[1])
                    r.exc.modified = 1'b1;
            end
        end
        return r;
    endfunction

    for (genvar k = 0; k < TLB_ENTRIES; k++) begin : g_cmp
        tlb_cmp u_cmp (
            .vpn2     (e_vpn2[k]),
            .asid     (e_asid[k]),
            .g        (e_g[k]),
            .cur_asid (cp0_entry_hi[7:0]),
            .i_vpn2   (i_vaddr[31:13]),
            .d_vpn2   (d_vaddr[31:13]),
            .p_vpn2   (cp0_entry_hi[31:13]),
            .i_hit    (i_hits[k]),
            .d_hit    (d_hits[k]),
            .p_hit    (p_hits[k])
        );
    end

    assign i_sel = first_hit(i_hits);
    assign d_sel = first_hit(d_hits);
    assign p_sel = first_hit(probe_hits);

    always_comb begin
        i_lo = '0;
        d_lo = '0;
        if (i_sel[IW])
            i_lo = i_vaddr[12] ? e_lo1[i_sel[IW-1:0]] : e_lo0[i_sel[IW-1:0]];
        if (d_sel[IW])
            d_lo = d_vaddr[12] ? e_lo1[d_sel[IW-1:0]] : e_lo0[d_sel[IW-1:0]];
        i_lk = xlate(i_req, i_vaddr, i_sel[IW], i_lo, 1'b0);
        d_lk = xlate(d_req, d_vaddr, d_sel[IW], d_lo, d_write);
    end

    // Idle cycles load zeros so CP0 never sees stale exception flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_resp_valid <= 1'b0;
            i_paddr      <= '0;
            i_uncached   <= 1'b0;
            i_tlb_exc    <= '0;
            d_resp_valid <= 1'b0;
            d_paddr      <= '0;
            d_uncached   <= 1'b0;
            d_tlb_exc    <= '0;
        end else begin
            i_resp_valid <= i_req;
            i_paddr      <= i_lk.paddr;
            i_uncached   <= i_lk.uncached;
            i_tlb_exc    <= i_lk.exc;
            d_resp_valid <= d_req;
            d_paddr      <= d_lk.paddr;
            d_uncached   <= d_lk.uncached;
            d_tlb_exc    <= d_lk.exc;
        end
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                accept    = cmd_valid && (tlb_type inside {TLB_P, TLB_R, TLB_WI, TLB_WR});
                if (accept && tlb_type == TLB_P)
                    state_nx = S_PROBE;
            end
            S_PROBE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    assign do_write = accept && (tlb_type == TLB_WI || tlb_type == TLB_WR);
    assign w_idx    = (tlb_type == TLB_WR) ? rnd : cp0_index[IW-1:0];
    assign r_idx    = cp0_index[IW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            e_vpn2 <= '0;
            e_asid <= '0;
            e_g    <= '0;
            e_lo0  <= '0;
            e_lo1  <= '0;
        end else if (do_write) begin
            e_vpn2[w_idx] <= cp0_entry_hi[31:13];
            e_asid[w_idx] <= cp0_entry_hi[7:0];
            e_g[w_idx]    <= cp0_entry_lo0[0] & cp0_entry_lo1[0];
            e_lo0[w_idx]  <= cp0_entry_lo0[25:1];
            e_lo1[w_idx]  <= cp0_entry_lo1[25:1];
        end
    end

    always_comb begin
        resp_fire = 1'b0;
        resp_nx   = '0;
        if (state == S_PROBE) begin
            resp_fire     = 1'b1;
            resp_nx.index = p_sel[IW] ? 32'(p_sel[IW-1:0]) : 32'h8000_0000;
        end else if (accept && tlb_type == TLB_R) begin
            resp_fire         = 1'b1;
            resp_nx.index     = cp0_index;
            resp_nx.entry_hi  = {e_vpn2[r_idx], 5'b0, e_asid[r_idx]};
            resp_nx.entry_lo0 = {6'b0, e_lo0[r_idx], e_g[r_idx]};
            resp_nx.entry_lo1 = {6'b0, e_lo1[r_idx], e_g[r_idx]};
        end else if (do_write) begin
            resp_fire = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            mmu_resp   <= '0;
            probe_hits <= '0;
        end else begin
            resp_valid <= resp_fire;
            if (resp_fire)
                mmu_resp <= resp_nx;
            if (accept && tlb_type == TLB_P)
                probe_hits <= p_hits;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            rnd <= TOP_IDX;
        else if (rnd <= cp0_wired[IW-1:0] || cp0_wired >= 32'(TLB_ENTRIES))
            rnd <= TOP_IDX;
        else
            rnd <= rnd - 1'b1;
    end

    assign random = {{(32-IW){1'b0}}, rnd};
endmodule
